// File: rtl/fpacket_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpacket_pkg
// Description : Shared constants, state encoding and helpers for the frame
//               parser front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package fpacket_pkg;

  localparam int WORD_WIDTH          = 16;
  localparam int TIMER_WIDTH         = 16;
  localparam int FRAME_PAYLOAD_BYTES = 10;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  localparam int SRC = 0;
  localparam int BAT = 2;
  localparam int VAL = 4;
  localparam int CLU = 6;
  localparam int DST = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIELD = 3'd1,
    ST_CSUM  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_BUSY  = 3'd4
  } state_t;

  function automatic logic [WORD_WIDTH-1:0] field_word(input logic [7:0] msb,
                                                       input logic [7:0] lsb);
    return {msb, lsb};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpacket_timer.sv
`default_nettype none
// ============================================================================
// Module      : fpacket_timer
// Description : Loadable up-counter with clear and terminal-count flag. Load
//               sets a new terminal value and restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fpacket_timer
  import fpacket_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clock,
  input  logic             nrst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_term;

  // The count parks at the terminal value so the flag stays asserted.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_count <= '0;
      r_term  <= '0;
    end else if (load) begin
      r_count <= '0;
      r_term  <= load_value;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != r_term) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == r_term);

endmodule
`default_nettype wire

// File: rtl/fpacket_parser.sv
`default_nettype none
// ============================================================================
// Module      : fpacket_parser
// Description : Byte-serial frame parser; validates SOF and XOR checksum,
//               latches five 16-bit fields, pulses en and holds until the
//               core's done_reward rising edge. Build option: SELF_FILTER_EN
//               drops good frames whose source equals my_node_id.
// Revision    : 1.0 - initial release
// ============================================================================
module fpacket_parser
  import fpacket_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEFAULT,
  parameter int         BYTE_TIMEOUT = 255,
  parameter int         BUSY_TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic                  done_reward,
  output logic                  en,
  output logic [WORD_WIDTH-1:0] fsourceID,
  output logic [WORD_WIDTH-1:0] fbatteryStat,
  output logic [WORD_WIDTH-1:0] fValue,
  output logic [WORD_WIDTH-1:0] fclusterID,
  output logic [WORD_WIDTH-1:0] fdestinationID,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic [7:0]            err_count
);

  state_t                r_state;
  logic [3:0]            r_idx;
  logic [7:0]            r_xor;
  logic [7:0]            r_shadow [FRAME_PAYLOAD_BYTES];
  logic                  r_done_q;
  logic                  r_en;
  logic                  r_busy;
  logic                  r_rx_ready;
  logic [15:0]           r_pkt_count;
  logic [7:0]            r_err_count;
  logic [WORD_WIDTH-1:0] r_src, r_bat, r_val, r_clu, r_dst;

  logic                   w_accept;
  logic                   w_expired;
  logic                   w_done_edge;
  logic                   w_last_payload;
  logic                   w_csum_ok;
  logic                   w_self_drop;
  logic                   w_byte_abort;
  logic                   w_state_change;
  logic [TIMER_WIDTH-1:0] w_timer_value;

  assign w_accept       = rx_valid && r_rx_ready;
  assign w_done_edge    = done_reward && !r_done_q;
  assign w_last_payload = (r_idx == 4'(FRAME_PAYLOAD_BYTES - 1));
  assign w_csum_ok      = (rx_data == r_xor);
  assign w_byte_abort   = w_expired && !w_accept;

`ifdef SELF_FILTER_EN
  assign w_self_drop = (field_word(r_shadow[SRC], r_shadow[SRC+1]) == my_node_id);
`else
  logic w_unused_node_id;
  assign w_self_drop      = 1'b0;
  assign w_unused_node_id = ^my_node_id;
`endif

  always_comb begin
    w_state_change = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_change = w_accept && (rx_data == SOF_BYTE);
      ST_FIELD: w_state_change = (w_accept && w_last_payload) || w_byte_abort;
      ST_CSUM:  w_state_change = w_accept || w_byte_abort;
      ST_ISSUE: w_state_change = 1'b1;
      ST_BUSY:  w_state_change = w_done_edge || w_expired;
      default:  w_state_change = 1'b1;
    endcase
  end

  // BUSY counts from its own first cycle, so the flag fires on cycle BUSY_TIMEOUT.
  assign w_timer_value = (r_state == ST_ISSUE) ? TIMER_WIDTH'(BUSY_TIMEOUT - 1)
                                               : TIMER_WIDTH'(BYTE_TIMEOUT);

  fpacket_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clock      (clock),
    .nrst       (nrst),
    .clear      (w_accept),
    .load       (w_state_change),
    .load_value (w_timer_value),
    .expired    (w_expired)
  );

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_xor       <= '0;
      r_done_q    <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_ready  <= 1'b1;
      r_pkt_count <= '0;
      r_err_count <= '0;
      r_src       <= '0;
      r_bat       <= '0;
      r_val       <= '0;
      r_clu       <= '0;
      r_dst       <= '0;
      for (int i = 0; i < FRAME_PAYLOAD_BYTES; i++) r_shadow[i] <= '0;
    end else begin
      r_done_q <= done_reward;
      r_en     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (rx_data == SOF_BYTE)) begin
            r_idx   <= '0;
            r_xor   <= '0;
            r_state <= ST_FIELD;
          end
        end
        ST_FIELD: begin
          if (w_accept) begin
            r_shadow[r_idx] <= rx_data;
            r_xor           <= r_xor ^ rx_data;
            r_idx           <= r_idx + 4'd1;
            if (w_last_payload) r_state <= ST_CSUM;
          end else if (w_expired) begin
            r_err_count <= sat_inc8(r_err_count);
            r_state     <= ST_IDLE;
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            if (!w_csum_ok) begin
              r_err_count <= sat_inc8(r_err_count);
              r_state     <= ST_IDLE;
            end else if (w_self_drop) begin
              r_state <= ST_IDLE;
            end else begin
              r_src      <= field_word(r_shadow[SRC], r_shadow[SRC+1]);
              r_bat      <= field_word(r_shadow[BAT], r_shadow[BAT+1]);
              r_val      <= field_word(r_shadow[VAL], r_shadow[VAL+1]);
              r_clu      <= field_word(r_shadow[CLU], r_shadow[CLU+1]);
              r_dst      <= field_word(r_shadow[DST], r_shadow[DST+1]);
              r_en       <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= ST_ISSUE;
            end
          end else if (w_expired) begin
            r_err_count <= sat_inc8(r_err_count);
            r_state     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_pkt_count <= r_pkt_count + 16'd1;
          r_busy      <= 1'b1;
          r_state     <= ST_BUSY;
        end
        ST_BUSY: begin
          if (w_done_edge) begin
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (w_expired) begin
            r_err_count <= sat_inc8(r_err_count);
            r_busy      <= 1'b0;
            r_rx_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_ready       = r_rx_ready;
  assign en             = r_en;
  assign busy           = r_busy;
  assign pkt_count      = r_pkt_count;
  assign err_count      = r_err_count;
  assign fsourceID      = r_src;
  assign fbatteryStat   = r_bat;
  assign fValue         = r_val;
  assign fclusterID     = r_clu;
  assign fdestinationID = r_dst;

endmodule
`default_nettype wire

// File: tb/tb_fpacket_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpacket_parser
// Description : Scoreboard bench for fpacket_parser: issued frames are queued
//               and popped by a monitor on every en pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpacket_parser;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] my_node_id = 16'h0001;
  logic        done_reward = 1'b0;
  logic        en;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [15:0] src, bat, val, clu, dst, pkt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;
  int   exp_pkt = 0;

  fpacket_parser dut (
    .clock          (clock),
    .nrst           (nrst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .my_node_id     (my_node_id),
    .done_reward    (done_reward),
    .en             (en),
    .fsourceID      (fsourceID),
    .fbatteryStat   (fbatteryStat),
    .fValue         (fValue),
    .fclusterID     (fclusterID),
    .fdestinationID (fdestinationID),
    .busy           (busy),
    .pkt_count      (pkt_count),
    .err_count      (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every en pulse must match the oldest queued frame.
  always @(negedge clock) begin
    exp_t e;
    if (nrst && en) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_en: got en=1 expected no pulse");
      end else begin
        e = sb_q.pop_front();
        check("sb_src", fsourceID, e.src);
        check("sb_bat", fbatteryStat, e.bat);
        check("sb_val", fValue, e.val);
        check("sb_clu", fclusterID, e.clu);
        check("sb_dst", fdestinationID, e.dst);
        check("sb_pkt", pkt_count, e.pkt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_wait: got rx_ready=0 expected 1 within 64 cycles");
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] s, input logic [15:0] b, input logic [15:0] v,
                            input logic [15:0] c, input logic [15:0] d, input logic [7:0] flip,
                            input int gap_after, input int gap_len, input bit issue);
    logic [7:0] p [10];
    logic [7:0] cs;
    exp_t       e;
    p  = '{s[15:8], s[7:0], b[15:8], b[7:0], v[15:8], v[7:0], c[15:8], c[7:0], d[15:8], d[7:0]};
    cs = 8'h00;
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) begin
      send_byte(p[i]);
      cs = cs ^ p[i];
      if (i == gap_after) tick(gap_len);
    end
    if (issue) begin
      e = '{src: s, bat: b, val: v, clu: c, dst: d, pkt: 16'(exp_pkt)};
      sb_q.push_back(e);
      exp_pkt++;
    end
    send_byte(cs ^ flip);
  endtask

  task automatic pulse_done();
    done_reward = 1'b1;
    tick(1);
    done_reward = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_en"}, en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkt"}, pkt_count, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_src"}, fsourceID, 0);
    check({tag, "_dst"}, fdestinationID, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    tick(3);
    nrst = 1'b1;
    tick(1);
    check_reset_state("reset");

    // Bad checksum (92 instead of 93): no en, error counted, outputs untouched.
    send_frame(16'h0001, 16'h8000, 16'h0010, 16'h0001, 16'h0003, 8'h01, -1, 0, 1'b0);
    bump_err();
    check("badcs_err", err_count, exp_err);
    check("badcs_src", fsourceID, 0);
    check("badcs_rx_ready", rx_ready, 1);

    send_byte(8'h3C);
    send_byte(8'h77);
    check("junk_err", err_count, exp_err);

    // Good frame: en the cycle after the checksum byte.
    send_frame(16'h0001, 16'h8000, 16'h0010, 16'h0001, 16'h0003, 8'h00, -1, 0, 1'b1);
    check("good_en_latency", en, 1);
    tick(1);
    check("good_en_one_cycle", en, 0);
    check("good_busy", busy, 1);
    check("good_rx_ready_low", rx_ready, 0);
    check("good_pkt", pkt_count, 1);
    tick(5);
    check("good_hold_rx_ready", rx_ready, 0);
    check("good_hold_val", fValue, 16'h0010);
    pulse_done();
    check("good_release_rx_ready", rx_ready, 1);
    check("good_release_busy", busy, 0);
    check("good_release_bat", fbatteryStat, 16'h8000);

    // Inter-byte timeout: 256 idle cycles after 4th payload byte aborts.
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    tick(256);
    bump_err();
    check("gap256_err", err_count, exp_err);
    check("gap256_rx_ready", rx_ready, 1);

    // 255 idle cycles is still within the limit.
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 8'h00, 3, 255, 1'b1);
    tick(1);
    check("gap255_err", err_count, exp_err);
    pulse_done();

    // done_reward already high on BUSY entry must not release.
    done_reward = 1'b1;
    send_frame(16'hAAAA, 16'h5555, 16'h0102, 16'h0304, 16'h0506, 8'h00, -1, 0, 1'b1);
    tick(3);
    check("dhigh_busy", busy, 1);
    done_reward = 1'b0;
    tick(1);
    check("dlow_busy", busy, 1);
    done_reward = 1'b1;
    tick(1);
    check("drise_busy", busy, 0);
    check("drise_rx_ready", rx_ready, 1);
    done_reward = 1'b0;

    // Busy timeout: released after BUSY_TIMEOUT cycles with error.
    send_frame(16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h000B, 8'h00, -1, 0, 1'b1);
    tick(4096);
    check("bto_busy_at_limit", busy, 1);
    tick(1);
    bump_err();
    check("bto_busy", busy, 0);
    check("bto_err", err_count, exp_err);
    check("bto_rx_ready", rx_ready, 1);

    // Self filter: source 0001 equals my_node_id.
    my_node_id = 16'h0001;
`ifdef SELF_FILTER_EN
    send_frame(16'h0001, 16'h8000, 16'h0010, 16'h0001, 16'h0003, 8'h00, -1, 0, 1'b0);
    tick(1);
    check("self_rx_ready", rx_ready, 1);
`else
    send_frame(16'h0001, 16'h8000, 16'h0010, 16'h0001, 16'h0003, 8'h00, -1, 0, 1'b1);
    tick(1);
    pulse_done();
`endif
    check("self_pkt", pkt_count, exp_pkt);
    check("self_err", err_count, exp_err);
    send_frame(16'h0002, 16'h8000, 16'h0010, 16'h0001, 16'h0003, 8'h00, -1, 0, 1'b1);
    tick(1);
    check("other_pkt", pkt_count, exp_pkt);
    pulse_done();

    // Reset during BUSY.
    send_frame(16'h4321, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 8'h00, -1, 0, 1'b1);
    tick(2);
    nrst = 1'b0;
    tick(1);
    check_reset_state("rst_busy");
    nrst = 1'b1;
    exp_err = 0;
    exp_pkt = 0;

    // Reset mid-FIELD, then a clean frame.
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'h22);
    nrst = 1'b0;
    tick(1);
    check_reset_state("rst_field");
    nrst = 1'b1;
    send_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 8'h00, -1, 0, 1'b1);
    tick(1);
    pulse_done();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 8'hFF, -1, 0, 1'b0);
      bump_err();
      if (i == 199) check("sat_err_200", err_count, exp_err);
    end
    check("sat_err_255", err_count, 255);
    check("sat_pkt", pkt_count, exp_pkt);

    tick(5);
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
